// File: rtl/mbldcm_ramp_controller.sv
// Start/stop sequencer for one BLDC channel: phase preset and alignment
// dwell, divider ramp from start down to target, run at speed, and a
// controlled ramp back to the start divider before halting.
module mbldcm_ramp_controller #(
  parameter logic [3:0] pTotalPhaseStages = 4'd12
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic        iStopReq,
  input  logic        iAbort,
  input  logic [31:0] iStartDiv,
  input  logic [31:0] iTargetDiv,
  input  logic [31:0] iStepDiv,
  input  logic [31:0] iStepInterval,
  input  logic [31:0] iAlignCycles,
  input  logic [3:0]  iAlignPhase,
  output logic [31:0] oDiv,
  output logic        oStop,
  output logic [3:0]  oPhaseUpdate,
  output logic        oLatchPhaseUpdate,
  output logic        oBusy,
  output logic        oAtSpeed
);

  localparam logic [3:0] MaxPhase = pTotalPhaseStages - 4'd1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_RAMP, S_RUN, S_DECEL} state_t;

  state_t      state_q, state_d;
  logic [31:0] div_q, div_d;
  logic        stop_q, stop_d;
  logic [3:0]  phase_q, phase_d;
  logic        latch_q, latch_d;
  logic        busy_q, busy_d;
  logic        at_speed_q, at_speed_d;
  // Operating point captured at start; host changes afterwards are ignored.
  logic [31:0] start_div_q, start_div_d;
  logic [31:0] target_div_q, target_div_d;
  logic [31:0] step_q, step_d;
  logic [31:0] interval_q, interval_d;
  // Shared down-counter: alignment dwell in ALIGN, step interval in RAMP/DECEL.
  logic [31:0] cnt_q, cnt_d;

  logic [32:0] diff, sum;
  logic [31:0] reload;
  logic        expired;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    latch_d      = 1'b0;
    cnt_d        = cnt_q;
    start_div_d  = start_div_q;
    target_div_d = target_div_q;
    step_d       = step_q;
    interval_d   = interval_q;
    // 33-bit arithmetic exposes underflow/overflow in the carry bit.
    diff         = {1'b0, div_q} - {1'b0, step_q};
    sum          = {1'b0, div_q} + {1'b0, step_q};
    reload       = interval_q - 32'd1;
    expired      = (cnt_q == 32'd0);

    if (iAbort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart && !iStopReq) begin
            start_div_d  = iStartDiv;
            target_div_d = iTargetDiv;
            step_d       = (iStepDiv == 32'd0) ? 32'd1 : iStepDiv;
            interval_d   = (iStepInterval == 32'd0) ? 32'd1 : iStepInterval;
            phase_d      = (iAlignPhase > MaxPhase) ? MaxPhase : iAlignPhase;
            latch_d      = 1'b1;
            cnt_d        = iAlignCycles;
            state_d      = S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (iStopReq) begin
            state_d = S_IDLE;
          end else if (cnt_q <= 32'd1) begin
            // A dwell of 0 still spends one cycle in ALIGN.
            state_d = S_RAMP;
            div_d   = start_div_q;
            cnt_d   = reload;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_RAMP: begin
          if (iStopReq) begin
            state_d = S_DECEL;
            cnt_d   = reload;
          end else if (start_div_q <= target_div_q) begin
            // Nothing to accelerate: jump to target at the first expiry.
            if (expired) begin
              div_d   = target_div_q;
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end else if (div_q == target_div_q) begin
            state_d = S_RUN;
          end else if (expired) begin
            div_d = (diff[32] || (diff[31:0] < target_div_q)) ? target_div_q : diff[31:0];
            cnt_d = reload;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_RUN: begin
          if (iStopReq) begin
            state_d = S_DECEL;
            cnt_d   = reload;
          end
        end
        S_DECEL: begin
          if (div_q == start_div_q) begin
            state_d = S_IDLE;
          end else if (expired) begin
            div_d = (sum > {1'b0, start_div_q}) ? start_div_q : sum[31:0];
            cnt_d = reload;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d     = (state_d != S_IDLE);
    at_speed_d = (state_d == S_RUN);
    stop_d     = !((state_d == S_RAMP) || (state_d == S_RUN) || (state_d == S_DECEL));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_q      <= S_IDLE;
      div_q        <= 32'hFFFF_FFFF;
      stop_q       <= 1'b1;
      phase_q      <= 4'd0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      at_speed_q   <= 1'b0;
      start_div_q  <= 32'd0;
      target_div_q <= 32'd0;
      step_q       <= 32'd1;
      interval_q   <= 32'd1;
      cnt_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      stop_q       <= stop_d;
      phase_q      <= phase_d;
      latch_q      <= latch_d;
      busy_q       <= busy_d;
      at_speed_q   <= at_speed_d;
      start_div_q  <= start_div_d;
      target_div_q <= target_div_d;
      step_q       <= step_d;
      interval_q   <= interval_d;
      cnt_q        <= cnt_d;
    end
  end

  assign oDiv              = div_q;
  assign oStop             = stop_q;
  assign oPhaseUpdate      = phase_q;
  assign oLatchPhaseUpdate = latch_q;
  assign oBusy             = busy_q;
  assign oAtSpeed          = at_speed_q;

endmodule

// File: tb/tb_mbldcm_ramp_controller.sv
// Bench for mbldcm_ramp_controller: directed and randomized start/stop runs
// compared cycle by cycle against expected divider/flag traces.
module tb_mbldcm_ramp_controller;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iStart = 1'b0, iStopReq = 1'b0, iAbort = 1'b0;
  logic [31:0] iStartDiv = '0, iTargetDiv = '0, iStepDiv = '0;
  logic [31:0] iStepInterval = '0, iAlignCycles = '0;
  logic [3:0]  iAlignPhase = '0;
  logic [31:0] oDiv;
  logic        oStop, oLatchPhaseUpdate, oBusy, oAtSpeed;
  logic [3:0]  oPhaseUpdate;

  int tests = 0;
  int fails = 0;

  // Reference state: last divider/phase the block should present.
  logic [31:0] m_div;
  logic [3:0]  m_phase;
  logic [31:0] q_ramp[$];
  longint      r_start, r_target, r_step, r_int;
  int          r_align;

  mbldcm_ramp_controller dut (
    .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iStopReq(iStopReq),
    .iAbort(iAbort), .iStartDiv(iStartDiv), .iTargetDiv(iTargetDiv),
    .iStepDiv(iStepDiv), .iStepInterval(iStepInterval), .iAlignCycles(iAlignCycles),
    .iAlignPhase(iAlignPhase), .oDiv(oDiv), .oStop(oStop), .oPhaseUpdate(oPhaseUpdate),
    .oLatchPhaseUpdate(oLatchPhaseUpdate), .oBusy(oBusy), .oAtSpeed(oAtSpeed)
  );

  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [39:0] ev(input logic [31:0] d, input logic st, input logic bz,
                                     input logic at, input logic la, input logic [3:0] ph);
    return {d, st, bz, at, la, ph};
  endfunction

  task automatic chk(input string tag, input logic [39:0] e);
    logic [39:0] o;
    o = {oDiv, oStop, oBusy, oAtSpeed, oLatchPhaseUpdate, oPhaseUpdate};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: div/stop/busy/atspd/latch/phase observed %h_%b%b%b%b_%h expected %h_%b%b%b%b_%h",
             tag, o[39:8], o[7], o[6], o[5], o[4], o[3:0], e[39:8], e[7], e[6], e[5], e[4], e[3:0]);
    end
  endtask

  task automatic chk_tick(input string tag, input logic [39:0] e);
    chk(tag, e);
    tick();
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, ev(m_div, 1'b1, 1'b0, 1'b0, 1'b0, m_phase));
  endtask

  // Issue a start and precompute the divider trace of the whole RAMP phase.
  task automatic begin_run(input longint st, input longint tg, input longint sp,
                           input longint iv, input int al, input int ph);
    longint cur, nx;
    r_start  = st;
    r_target = tg;
    r_step   = (sp == 0) ? 1 : sp;
    r_int    = (iv == 0) ? 1 : iv;
    r_align  = (al == 0) ? 1 : al;
    iStartDiv = 32'(st); iTargetDiv = 32'(tg); iStepDiv = 32'(sp);
    iStepInterval = 32'(iv); iAlignCycles = 32'(al); iAlignPhase = 4'(ph);
    iStart = 1'b1;
    chk_tick("idle_before_start", ev(m_div, 1'b1, 1'b0, 1'b0, 1'b0, m_phase));
    iStart = 1'b0;
    // Scramble host inputs: the run must use the captured values.
    iStartDiv = $urandom; iTargetDiv = $urandom; iStepDiv = $urandom;
    iStepInterval = $urandom; iAlignCycles = $urandom; iAlignPhase = 4'($urandom);
    m_phase = (ph > 11) ? 4'd11 : 4'(ph);
    q_ramp.delete();
    if (st <= tg) begin
      repeat (int'(r_int)) q_ramp.push_back(32'(st));
    end else begin
      cur = st;
      while (cur != tg) begin
        repeat (int'(r_int)) q_ramp.push_back(32'(cur));
        nx = cur - r_step;
        if (nx < tg) nx = tg;
        cur = nx;
      end
      q_ramp.push_back(32'(tg));
    end
  endtask

  task automatic align_phase(input int limit);
    int n;
    n = (limit < r_align) ? limit : r_align;
    for (int k = 0; k < n; k++)
      chk_tick("align", ev(m_div, 1'b1, 1'b1, 1'b0, (k == 0), m_phase));
  endtask

  task automatic ramp_phase(input int limit);
    int n;
    n = (limit < q_ramp.size()) ? limit : q_ramp.size();
    for (int i = 0; i < n; i++) begin
      m_div = q_ramp[i];
      chk_tick("ramp", ev(q_ramp[i], 1'b0, 1'b1, 1'b0, 1'b0, m_phase));
    end
    if (n < q_ramp.size()) m_div = q_ramp[n];
    else m_div = 32'(r_target);
  endtask

  task automatic run_phase(input int n);
    repeat (n) chk_tick("run", ev(m_div, 1'b0, 1'b1, 1'b1, 1'b0, m_phase));
  endtask

  // Controlled stop from RAMP (at=0) or RUN (at=1), then the ramp back up.
  task automatic decel(input logic at);
    longint cur, nx;
    iStopReq = 1'b1;
    chk_tick("stop_edge", ev(m_div, 1'b0, 1'b1, at, 1'b0, m_phase));
    iStopReq = 1'b0;
    cur = m_div;
    while (cur != r_start) begin
      repeat (int'(r_int)) chk_tick("decel", ev(32'(cur), 1'b0, 1'b1, 1'b0, 1'b0, m_phase));
      nx = cur + r_step;
      if (nx > r_start) nx = r_start;
      cur = nx;
    end
    chk_tick("decel_last", ev(32'(r_start), 1'b0, 1'b1, 1'b0, 1'b0, m_phase));
    m_div = 32'(r_start);
    idle_chk("idle_after_decel");
  endtask

  initial begin
    int k;
    // Reset values.
    tick(); tick();
    m_div = 32'hFFFF_FFFF; m_phase = 4'd0;
    chk("reset_values", ev(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    iReset_n = 1'b1;
    tick();
    idle_chk("idle_after_reset");

    // Nominal run: 1000 -> 800 -> 600 -> 400 every 4 cycles, align 3, phase 5.
    begin_run(1000, 400, 200, 4, 3, 5);
    align_phase(99); ramp_phase(999); run_phase(3); decel(1'b1);

    // Clamps: step/interval 0 -> 1, phase 15 -> 11.
    begin_run(100, 97, 0, 0, 2, 15);
    align_phase(99); ramp_phase(999); run_phase(2); decel(1'b1);

    // Saturating overshoot and stop from RUN: 450 -> 750 -> 1000 -> IDLE.
    begin_run(1000, 450, 300, 2, 1, 3);
    align_phase(99); ramp_phase(999); run_phase(2); decel(1'b1);

    // Abort in RAMP at 800.
    begin_run(1000, 400, 200, 4, 2, 7);
    align_phase(99); ramp_phase(4);
    iAbort = 1'b1;
    chk_tick("abort_edge", ev(m_div, 1'b0, 1'b1, 1'b0, 1'b0, m_phase));
    iAbort = 1'b0;
    idle_chk("abort_idle_800");
    // Start blocked by stop request, then by abort.
    iStopReq = 1'b1; iStart = 1'b1; iStartDiv = 32'd77; iAlignPhase = 4'd2;
    chk_tick("start_blocked_stop", ev(m_div, 1'b1, 1'b0, 1'b0, 1'b0, m_phase));
    chk_tick("start_blocked_stop2", ev(m_div, 1'b1, 1'b0, 1'b0, 1'b0, m_phase));
    iStopReq = 1'b0; iAbort = 1'b1;
    chk_tick("start_blocked_abort", ev(m_div, 1'b1, 1'b0, 1'b0, 1'b0, m_phase));
    iAbort = 1'b0; iStart = 1'b0;
    idle_chk("still_idle");

    // Start below target: jumps to target at first expiry; start in RUN ignored.
    begin_run(300, 500, 50, 3, 1, 2);
    align_phase(99); ramp_phase(999); run_phase(1);
    iStart = 1'b1; iStartDiv = 32'd9999; iTargetDiv = 32'd1; iAlignPhase = 4'd9;
    chk_tick("start_in_run", ev(m_div, 1'b0, 1'b1, 1'b1, 1'b0, m_phase));
    iStart = 1'b0;
    run_phase(2); decel(1'b1);

    // Stop during ALIGN returns to IDLE at once with oStop held high.
    begin_run(500, 200, 100, 2, 5, 4);
    align_phase(2);
    iStopReq = 1'b1;
    chk_tick("align_stop_edge", ev(m_div, 1'b1, 1'b1, 1'b0, 1'b0, m_phase));
    iStopReq = 1'b0;
    idle_chk("align_stop_idle");

    // Underflowing step saturates at target.
    begin_run(100, 10, 200, 1, 1, 0);
    align_phase(99); ramp_phase(999); run_phase(1); decel(1'b1);

    // Decel add would overflow 32 bits; must clamp at start.
    begin_run(64'hFFFF_FFF0, 64'hFFFF_FF00, 64'h80, 1, 1, 1);
    align_phase(99); ramp_phase(999); run_phase(1); decel(1'b1);

    // Stop mid-RAMP.
    begin_run(900, 300, 150, 2, 2, 6);
    align_phase(99); ramp_phase(3); decel(1'b0);

    // Reset mid-RAMP at oDiv=900.
    begin_run(1000, 100, 100, 3, 1, 9);
    align_phase(99); ramp_phase(3);
    iReset_n = 1'b0;
    chk_tick("reset_edge_ramp", ev(32'd900, 1'b0, 1'b1, 1'b0, 1'b0, m_phase));
    iReset_n = 1'b1;
    m_div = 32'hFFFF_FFFF; m_phase = 4'd0;
    chk("reset_mid_ramp", ev(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));

    // Randomized runs.
    repeat (10) begin
      begin_run($urandom_range(1, 1000), $urandom_range(1, 1000), $urandom_range(20, 250),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 15));
      align_phase(99);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q_ramp.size() - 1);
        ramp_phase(k); decel(1'b0);
      end else begin
        ramp_phase(999); run_phase($urandom_range(1, 3)); decel(1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbldcm_ramp_controller.md
# mbldcm_ramp_controller

Start/stop sequencer for one BLDC motor channel; it drives the divider, stop and phase-preset inputs of the phase controller. On a start command it presets the commutation phase, holds the rotor for an alignment dwell, then ramps the step divider from a start value down to a target value, which is an acceleration. On a stop command it ramps back up to the start value and then halts. It sits between the register/host interface and the phase controller.

## Interface
- pTotalPhaseStages, 4'd12, number of commutation phases; the alignment phase is clamped to pTotalPhaseStages-1.
- iClock  in  1  clock, all logic on rising edge.
- iReset_n  in  1  reset, synchronous, active-low.
- iStart  in  1  start pulse; acted on only in IDLE.
- iStopReq  in  1  controlled-stop request, level or pulse.
- iAbort  in  1  emergency stop, highest priority.
- iStartDiv  in  32  divider at ramp start and end (slow speed).
- iTargetDiv  in  32  running divider (fast speed).
- iStepDiv  in  32  divider change per ramp step; 0 is treated as 1.
- iStepInterval  in  32  clock cycles between ramp steps; 0 is treated as 1.
- iAlignCycles  in  32  alignment dwell length in cycles.
- iAlignPhase  in  4  phase preset at start.
- oDiv  out  32  divider to the phase controller.
- oStop  out  1  stop to the phase controller.
- oPhaseUpdate  out  4  phase preset value.
- oLatchPhaseUpdate  out  1  one-cycle phase preset strobe.
- oBusy  out  1  high in any state other than IDLE.
- oAtSpeed  out  1  high in RUN.

## Operation
- States: IDLE, ALIGN, RAMP, RUN, DECEL. All outputs are registered.
- Reset values: state IDLE, oDiv=32'hFFFF_FFFF, oStop=1, oPhaseUpdate=0, oLatchPhaseUpdate=0, oBusy=0, oAtSpeed=0.
- Start capture: on iStart in IDLE, the block captures iStartDiv, iTargetDiv, step (min 1), interval (min 1), iAlignCycles, and the clamped iAlignPhase. Later input changes are ignored until the next start.
- IDLE: oStop=1. Start is accepted only if iStopReq=0 and iAbort=0; otherwise the block stays in IDLE.
- ALIGN:
  - oStop=1.
  - oLatchPhaseUpdate=1 in the first ALIGN cycle only, with oPhaseUpdate equal to the captured phase.
  - A dwell counter is loaded with iAlignCycles. ALIGN lasts max(iAlignCycles,1) cycles.
  - At the end of ALIGN the block goes to RAMP, with oDiv set to the captured start divider and oStop set to 0.
  - iStopReq during ALIGN goes to IDLE next cycle.
- RAMP:
  - An interval counter is loaded with interval-1 on entry.
  - On each expiry: oDiv <= (oDiv - step < target, or underflow) ? target : oDiv - step. The counter then reloads.
  - When oDiv == target, the block goes to RUN on the next cycle.
  - If start <= target, oDiv is set to target and the block enters RUN at the first expiry.
- RUN: oDiv holds, oAtSpeed=1, oStop=0.
- DECEL:
  - Entered from RAMP or RUN on iStopReq. The interval counter reloads on entry.
  - On each expiry: oDiv <= min(oDiv + step, start), with no 32-bit overflow.
  - When oDiv == start, the block goes to IDLE. oStop=1 is asserted on entry to IDLE.
- iAbort: from any state, the block goes to IDLE on the next edge. oStop=1, oDiv is held, and no ramp occurs.
- Priority: reset > iAbort > iStopReq > iStart > counter events.
- iStart outside IDLE is ignored. iStopReq in DECEL or IDLE has no effect.

## Timing
- iStart sampled at edge N: ALIGN state and oLatchPhaseUpdate=1 are visible after edge N, oBusy=1 from the same edge.
- The first RAMP step lands iStepInterval cycles after RAMP entry, and each later step is interval cycles after the previous one.
- Steps to reach RUN = ceil((start - target)/step). RUN is entered one cycle after oDiv == target.
- iStopReq/iAbort at edge M: the state changes after edge M. oStop rises after edge M for abort or ALIGN-stop, and one edge after the final DECEL step for DECEL.
- oLatchPhaseUpdate is never high for more than one consecutive cycle.

## Test plan
- Reset mid-RAMP (oDiv=900) -> the next cycle shows all reset values, including oDiv=FFFF_FFFF and oStop=1.
- Nominal run:
  - Stimulus: start=1000, target=400, step=200, interval=4, align=3, phase=5.
  - Latch strobe one cycle with phase 5.
  - ALIGN for 3 cycles.
  - oDiv goes 1000 -> 800 -> 600 -> 400, one step every 4 cycles.
  - oAtSpeed=1 the following cycle.
- Clamps: step=0, interval=0, phase=15, start=100, target=97 -> phase preset 11; oDiv steps by 1 every cycle 100 -> 99 -> 98 -> 97.
- Saturating overshoot: start=1000, target=450, step=300 -> 1000 -> 700 -> 450, then RUN; iStopReq in RUN -> 750 -> 1000 -> IDLE with oStop=1.
- Abort in RAMP at oDiv=800 -> IDLE next cycle, oStop=1, oDiv=800, oBusy=0; iStart with iStopReq=1 -> stays in IDLE.
- Start=300, target=500 -> oDiv=500 and RUN after the first interval; iStart while in RUN is ignored.
